// File: rtl/wave_pacer_if.sv
// FIFO read port plus held-sample output of the pacer; master is the pacer side.
// No latency of its own; the FIFO is expected to return data one cycle after fifo_rd_en.
interface wave_pacer_if;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] wave;
    logic        wave_valid;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output wave,
        output wave_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  wave,
        input  wave_valid
    );
endinterface

// File: rtl/wave_pacer.sv
// Pops one FIFO word every hold_ticks ticks and holds it on wave; tick->wave is 3 cycles.
// No backpressure: a due pop against an empty FIFO is an underrun, never a stall.
module wave_pacer #(
    parameter bit SWAP_HALVES      = 1'b0,
    parameter bit ZERO_ON_UNDERRUN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          tick,
    input  logic [15:0]   hold_ticks,
    input  logic          clear_stats,
    wave_pacer_if.master  bus,
    output logic          underrun,
    output logic [15:0]   underrun_cnt,
    output logic          missed_tick,
    output logic [31:0]   sample_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] tick_cnt, tick_cnt_nxt;
    logic [15:0] reload_val;
    logic        do_underrun;
    logic [31:0] cap_dat;
    logic [31:0] wave_q;
    logic        wave_valid_q;

    // A hold of 0 ticks behaves like 1: pop on every tick.
    assign reload_val = (hold_ticks == 16'd0) ? 16'd0 : hold_ticks - 16'd1;
    assign cap_dat    = SWAP_HALVES ? {bus.fifo_dout[15:0], bus.fifo_dout[31:16]}
                                    : bus.fifo_dout;

    assign bus.fifo_rd_en = (state == FETCH);
    assign bus.wave       = wave_q;
    assign bus.wave_valid = wave_valid_q;

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        do_underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && tick) begin
                    if (tick_cnt != 16'd0) begin
                        tick_cnt_nxt = tick_cnt - 16'd1;
                    end else begin
                        tick_cnt_nxt = reload_val;
                        if (!bus.fifo_empty) state_nxt = FETCH;
                        else                 do_underrun = 1'b1;
                    end
                end
            end
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Disabled pacer restarts with a due pop on the first tick after enable.
        if (!enable) tick_cnt_nxt = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= 16'd0;
            wave_q       <= 32'd0;
            wave_valid_q <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
            missed_tick  <= 1'b0;
            sample_cnt   <= 32'd0;
        end else begin
            state        <= state_nxt;
            tick_cnt     <= tick_cnt_nxt;
            wave_valid_q <= 1'b0;
            if (state == CAPTURE) begin
                wave_q       <= cap_dat;
                wave_valid_q <= 1'b1;
                sample_cnt   <= sample_cnt + 32'd1;
            end
            if (do_underrun && ZERO_ON_UNDERRUN) begin
                wave_q       <= 32'd0;
                wave_valid_q <= 1'b1;
            end
            if (tick && (state != IDLE)) missed_tick <= 1'b1;
            if (do_underrun) begin
                underrun <= 1'b1;
                if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
            // Clearing wins over a same-cycle underrun or missed tick.
            if (clear_stats) begin
                underrun     <= 1'b0;
                underrun_cnt <= 16'd0;
                missed_tick  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_pacer.sv
// Bench for wave_pacer: two instances (default params, and swap+zero-on-underrun) share stimulus;
// a tick-level reference model predicts pops, waves and stats per cycle.
module tb_wave_pacer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic        tick        = 1'b0;
    logic        clear_stats = 1'b0;
    logic [15:0] hold_ticks  = 16'd1;

    wave_pacer_if pif0();
    wave_pacer_if pif1();

    logic        und0, und1, miss0, miss1;
    logic [15:0] ucnt0, ucnt1;
    logic [31:0] scnt0, scnt1;

    wave_pacer #(.SWAP_HALVES(1'b0), .ZERO_ON_UNDERRUN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .hold_ticks(hold_ticks), .clear_stats(clear_stats), .bus(pif0),
        .underrun(und0), .underrun_cnt(ucnt0), .missed_tick(miss0), .sample_cnt(scnt0)
    );

    wave_pacer #(.SWAP_HALVES(1'b1), .ZERO_ON_UNDERRUN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .hold_ticks(hold_ticks), .clear_stats(clear_stats), .bus(pif1),
        .underrun(und1), .underrun_cnt(ucnt1), .missed_tick(miss1), .sample_cnt(scnt1)
    );

    localparam int K_RD = 0, K_WAVE = 1, K_UND = 2, K_MISS = 3, K_CLR = 4;
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] d;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] fq[$];
    int          cur = 0;
    int          busy_until = 0;
    int          acc = 0;
    int          next_due = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        exp_rd = 1'b0, exp_v0 = 1'b0, exp_v1 = 1'b0, exp_und = 1'b0, exp_miss = 1'b0;
    logic [31:0] exp_w0 = 32'd0, exp_w1 = 32'd0, exp_samp = 32'd0;
    logic [15:0] exp_ucnt = 16'd0;

    function automatic logic [31:0] swp(input logic [31:0] d);
        return {d[15:0], d[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cur, obs, exp);
        end
    endtask

    task automatic sched(input int c, input int k, input logic [31:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.d = d;
        evq.push_back(e);
    endtask

    task automatic push(input logic [31:0] d);
        fq.push_back(d);
        pif0.fifo_empty = 1'b0;
        pif1.fifo_empty = 1'b0;
    endtask

    // Model the current cycle's inputs, advance one clock, then check the new cycle.
    task automatic step();
        logic        was_reset;
        logic        idle;
        logic        pend_vld;
        logic [31:0] pend_dat;
        ev_t         keep[$];
        was_reset = reset;
        pend_vld  = 1'b0;
        pend_dat  = 32'd0;
        if (!reset) begin
            idle = (cur >= busy_until);
            if (tick && !idle) sched(cur + 1, K_MISS, 32'd0);
            if (!enable) begin
                next_due = acc;
            end else if (tick && idle) begin
                if (acc == next_due) begin
                    next_due = acc + ((hold_ticks == 16'd0) ? 1 : int'(hold_ticks));
                    if (!pif0.fifo_empty) begin
                        sched(cur + 1, K_RD, 32'd0);
                        sched(cur + 3, K_WAVE, fq[0]);
                        busy_until = cur + 3;
                    end else begin
                        sched(cur + 1, K_UND, 32'd0);
                    end
                end
                acc++;
            end
            if (clear_stats) sched(cur + 1, K_CLR, 32'd0);
        end
        if (pif0.fifo_rd_en === 1'b1 && fq.size() > 0) begin
            pend_dat = fq.pop_front();
            pend_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        cur++;
        tick        = 1'b0;
        clear_stats = 1'b0;
        if (was_reset) begin
            evq.delete(); fq.delete();
            exp_w0 = 32'd0; exp_w1 = 32'd0; exp_samp = 32'd0;
            exp_und = 1'b0; exp_ucnt = 16'd0; exp_miss = 1'b0;
            busy_until = 0; acc = 0; next_due = 0; pend_vld = 1'b0;
        end
        if (pend_vld) begin
            pif0.fifo_dout = pend_dat;
            pif1.fifo_dout = pend_dat;
        end
        pif0.fifo_empty = (fq.size() == 0);
        pif1.fifo_empty = (fq.size() == 0);

        exp_rd = 1'b0; exp_v0 = 1'b0; exp_v1 = 1'b0;
        foreach (evq[i]) begin
            if (evq[i].cyc == cur) begin
                case (evq[i].kind)
                    K_RD:   exp_rd = 1'b1;
                    K_WAVE: begin
                        exp_w0 = evq[i].d; exp_w1 = swp(evq[i].d);
                        exp_v0 = 1'b1;     exp_v1 = 1'b1;
                        exp_samp = exp_samp + 32'd1;
                    end
                    K_UND: begin
                        exp_und = 1'b1;
                        if (exp_ucnt != 16'hFFFF) exp_ucnt = exp_ucnt + 16'd1;
                        exp_w1 = 32'd0; exp_v1 = 1'b1;
                    end
                    K_MISS: exp_miss = 1'b1;
                    default: begin
                        exp_und = 1'b0; exp_ucnt = 16'd0; exp_miss = 1'b0;
                    end
                endcase
            end else begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;

        chk("rd_en0", {31'd0, pif0.fifo_rd_en}, {31'd0, exp_rd});
        chk("rd_en1", {31'd0, pif1.fifo_rd_en}, {31'd0, exp_rd});
        chk("wave0", pif0.wave, exp_w0);
        chk("wave1", pif1.wave, exp_w1);
        chk("wave_valid0", {31'd0, pif0.wave_valid}, {31'd0, exp_v0});
        chk("wave_valid1", {31'd0, pif1.wave_valid}, {31'd0, exp_v1});
        chk("underrun0", {31'd0, und0}, {31'd0, exp_und});
        chk("underrun1", {31'd0, und1}, {31'd0, exp_und});
        chk("underrun_cnt0", {16'd0, ucnt0}, {16'd0, exp_ucnt});
        chk("underrun_cnt1", {16'd0, ucnt1}, {16'd0, exp_ucnt});
        chk("missed_tick0", {31'd0, miss0}, {31'd0, exp_miss});
        chk("missed_tick1", {31'd0, miss1}, {31'd0, exp_miss});
        chk("sample_cnt0", scnt0, exp_samp);
        chk("sample_cnt1", scnt1, exp_samp);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick_then(input int gap);
        tick = 1'b1;
        step();
        idle_cycles(gap);
    endtask

    initial begin
        pif0.fifo_dout = 32'd0; pif0.fifo_empty = 1'b1;
        pif1.fifo_dout = 32'd0; pif1.fifo_empty = 1'b1;

        // Reset, then enable
        idle_cycles(3);
        reset  = 1'b0;
        enable = 1'b1;
        step();

        // Back-to-back samples with a one-tick hold
        hold_ticks = 16'd1;
        for (int i = 0; i < 3; i++) push($urandom);
        for (int i = 0; i < 3; i++) tick_then(4);

        // Four-tick hold, then a zero hold acting as one
        hold_ticks = 16'd4;
        push($urandom); push($urandom);
        for (int i = 0; i < 8; i++) tick_then(4);
        hold_ticks = 16'd0;
        push($urandom); push($urandom);
        for (int i = 0; i < 2; i++) tick_then(4);

        // Underruns on an empty FIFO, then a clear coinciding with an underrun
        for (int i = 0; i < 3; i++) tick_then(4);
        tick = 1'b1; clear_stats = 1'b1;
        step();
        idle_cycles(4);

        // Tick during a fetch is missed, then stats cleared
        push($urandom); push($urandom);
        tick = 1'b1; step();
        tick = 1'b1; step();
        idle_cycles(4);
        clear_stats = 1'b1;
        step();
        idle_cycles(2);

        // Halves swap on a known word
        push(32'h1234_5678);
        tick_then(4);

        // Reset during FETCH, then disabled ticks and re-enable
        push($urandom);
        tick = 1'b1; step();
        reset = 1'b1; step();
        reset = 1'b0; enable = 1'b0; hold_ticks = 16'd5;
        idle_cycles(2);
        tick_then(4);
        enable = 1'b1;
        step();
        push($urandom); push($urandom);
        for (int i = 0; i < 7; i++) tick_then(4);

        // Randomised pacing traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 4) push($urandom);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) hold_ticks = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) clear_stats = 1'b1;
            tick_then($urandom_range(0, 5));
        end
        idle_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
